// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture controller.
package cam_pkg;

    typedef enum logic [2:0] {
        OFF,
        PWR,
        WAKE,
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } cam_state_e;

    localparam int FIFO_DEPTH   = 4;
    localparam int PIX_PER_WORD = 4;

endpackage

// File: rtl/cam_word_fifo.sv
// Small word FIFO between the pixel packer and the downstream stream.
// The head word is presented on data/valid and stays put until ready.
module cam_word_fifo
    import cam_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         full,
    output logic         drop
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          wr_en;

    assign valid = (count != '0);
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop   = valid && ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && !wr_en;
    assign data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera sensor power sequencing plus single-frame luma capture,
// packing 4 pixels per word into a skid FIFO for the frame writer.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int MCLK_HALF   = 1,
    parameter int RST_CYCLES  = 1000,
    parameter int WAKE_CYCLES = 5000,
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 120,
    parameter int CNT_W       = 16
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [7:0]  cam_y_i,
    input  logic        cam_pclk_i,
    input  logic        cam_hsync_i,
    input  logic        cam_vsync_i,
    output logic        cam_mclk_o,
    output logic        cam_rst_o,
    output logic        cam_enb_o,
    output logic [31:0] px_data_o,
    output logic        px_valid_o,
    input  logic        px_ready_i
);

    localparam logic [CNT_W-1:0] FRAME_PIXELS = CNT_W'(H_PIXELS * V_LINES);
    localparam int PK_W = $clog2(PIX_PER_WORD);
    localparam int PK_BITS = 8 * (PIX_PER_WORD - 1);

    cam_state_e state, next_state;

    logic [CNT_W-1:0] seq_cnt, mclk_cnt, pixel_cnt, line_cnt;
    logic [1:0]       pclk_sync, hs_sync, vs_sync;
    logic [7:0]       y_s1, y_s2;
    logic             pclk_d, hs_d, vs_d;
    logic [PK_BITS-1:0] pk_data;
    logic [PK_W-1:0]  pk_cnt;
    logic             strobe, hs_fall, vs_fall, vs_rise;
    logic             start_cap, take_px, push, fifo_full, fifo_drop, frame_ok;

    // Data and hsync share the pclk synchronizer stage so a strobe sees matching values.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            pclk_sync <= '0;
            hs_sync   <= '0;
            vs_sync   <= '0;
            y_s1      <= '0;
            y_s2      <= '0;
            pclk_d    <= 1'b0;
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
        end else begin
            pclk_sync <= {pclk_sync[0], cam_pclk_i};
            hs_sync   <= {hs_sync[0], cam_hsync_i};
            vs_sync   <= {vs_sync[0], cam_vsync_i};
            y_s1      <= cam_y_i;
            y_s2      <= y_s1;
            pclk_d    <= pclk_sync[1];
            hs_d      <= hs_sync[1];
            vs_d      <= vs_sync[1];
        end
    end

    assign strobe  = pclk_sync[1] && !pclk_d;
    assign hs_fall = hs_d && !hs_sync[1];
    assign vs_fall = vs_d && !vs_sync[1];
    assign vs_rise = !vs_d && vs_sync[1];

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= OFF;
        end else begin
            state <= next_state;
        end
    end

    assign frame_ok = (pixel_cnt == FRAME_PIXELS) && !err_o;

    always_comb begin
        next_state = state;
        cam_enb_o  = 1'b1;
        cam_rst_o  = 1'b1;
        ready_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            OFF: begin
                cam_enb_o  = 1'b0;
                cam_rst_o  = 1'b0;
                next_state = PWR;
            end
            PWR: begin
                cam_rst_o = 1'b0;
                if (seq_cnt == CNT_W'(RST_CYCLES - 1)) next_state = WAKE;
            end
            WAKE: begin
                if (seq_cnt == CNT_W'(WAKE_CYCLES - 1)) next_state = IDLE;
            end
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) next_state = WAIT_VS;
            end
            WAIT_VS: begin
                busy_o = 1'b1;
                if (abort_i)      next_state = IDLE;
                else if (vs_fall) next_state = CAPTURE;
            end
            CAPTURE: begin
                busy_o = 1'b1;
                if (abort_i)      next_state = IDLE;
                else if (vs_rise) next_state = DONE;
            end
            DONE: begin
                done_o     = frame_ok;
                next_state = IDLE;
            end
            default: next_state = OFF;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            seq_cnt <= '0;
        end else if (next_state != state) begin
            seq_cnt <= '0;
        end else if (state == PWR || state == WAKE) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            mclk_cnt   <= '0;
            cam_mclk_o <= 1'b0;
        end else if (state == OFF) begin
            mclk_cnt   <= '0;
            cam_mclk_o <= 1'b0;
        end else if (mclk_cnt == CNT_W'(MCLK_HALF - 1)) begin
            mclk_cnt   <= '0;
            cam_mclk_o <= !cam_mclk_o;
        end else begin
            mclk_cnt <= mclk_cnt + 1'b1;
        end
    end

    assign start_cap = (state == IDLE) && start_i;
    assign take_px   = (state == CAPTURE) && !abort_i && strobe && hs_sync[1];
    assign push      = take_px && (pk_cnt == PK_W'(PIX_PER_WORD - 1));

    // A partial word left by an abort is dropped when the next start clears pk_cnt.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            pk_data   <= '0;
            pk_cnt    <= '0;
            pixel_cnt <= '0;
            line_cnt  <= '0;
        end else if (start_cap) begin
            pk_cnt    <= '0;
            pixel_cnt <= '0;
            line_cnt  <= '0;
        end else begin
            if (take_px) begin
                pk_data <= {y_s2, pk_data[PK_BITS-1:8]};
                pk_cnt  <= pk_cnt + 1'b1;
                if (pixel_cnt != '1) pixel_cnt <= pixel_cnt + 1'b1;
            end
            if (state == CAPTURE && !abort_i && hs_fall) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            err_o <= 1'b0;
        end else if (start_cap) begin
            err_o <= 1'b0;
        end else if (fifo_drop || (state == DONE && !frame_ok)) begin
            err_o <= 1'b1;
        end
    end

    cam_word_fifo #(.W(32)) u_fifo (
        .clk       (clk_i),
        .rst_n     (reset_n),
        .push      (push),
        .push_data ({y_s2, pk_data}),
        .ready     (px_ready_i),
        .data      (px_data_o),
        .valid     (px_valid_o),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

endmodule
